// File: rtl/err_capture.sv
// Error-event monitor: qualifies the err level over QUAL consecutive cycles, snapshots count,
// raises a level irq until acked and keeps saturating event / sticky missed statistics.
module err_capture #(
    parameter int CW   = 12,
    parameter int QUAL = 2,
    parameter int EW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          err,
    input  logic [CW-1:0] count,
    input  logic          ack,
    output logic          irq,
    output logic [CW-1:0] snap_count,
    output logic [EW-1:0] events,
    output logic          missed,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_QUAL    = 2'd1,
        S_PEND    = 2'd2,
        S_WAITLOW = 2'd3
    } state_t;

    localparam logic [4:0] QUAL_W = 5'(QUAL);

    state_t        state_q, state_d;
    logic          err_d_q;
    logic [CW-1:0] cand_q, cand_d;
    logic [3:0]    qcnt_q, qcnt_d;
    logic [CW-1:0] snap_q, snap_d;
    logic [EW-1:0] events_q, events_d;
    logic          irq_q, irq_d;
    logic          missed_q, missed_d;

    logic          err_rise;
    logic          do_commit;
    logic [CW-1:0] commit_val;

    assign err_rise = err & ~err_d_q;

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        qcnt_d     = qcnt_q;
        snap_d     = snap_q;
        events_d   = events_q;
        irq_d      = irq_q;
        missed_d   = missed_q;
        do_commit  = 1'b0;
        commit_val = cand_q;

        case (state_q)
            S_IDLE: begin
                if (err) begin
                    cand_d = count;
                    if (QUAL == 1) begin
                        do_commit  = 1'b1;
                        commit_val = count;
                    end else begin
                        qcnt_d  = 4'd1;
                        state_d = S_QUAL;
                    end
                end
            end
            S_QUAL: begin
                if (!err) begin
                    state_d = S_IDLE;
                end else if (({1'b0, qcnt_q} + 5'd1) == QUAL_W) begin
                    do_commit  = 1'b1;
                    commit_val = cand_q;
                end else begin
                    qcnt_d = qcnt_q + 4'd1;
                end
            end
            S_PEND: begin
                // ack takes priority over a coincident rising edge
                if (ack) begin
                    irq_d   = 1'b0;
                    state_d = err ? S_WAITLOW : S_IDLE;
                end else if (err_rise) begin
                    missed_d = 1'b1;
                end
            end
            S_WAITLOW: begin
                if (!err) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (do_commit) begin
            snap_d  = commit_val;
            irq_d   = 1'b1;
            state_d = S_PEND;
            if (events_q != {EW{1'b1}}) begin
                events_d = events_q + EW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            err_d_q  <= 1'b0;
            cand_q   <= '0;
            qcnt_q   <= '0;
            snap_q   <= '0;
            events_q <= '0;
            irq_q    <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            err_d_q  <= err;
            cand_q   <= cand_d;
            qcnt_q   <= qcnt_d;
            snap_q   <= snap_d;
            events_q <= events_d;
            irq_q    <= irq_d;
            missed_q <= missed_d;
        end
    end

    assign irq        = irq_q;
    assign snap_count = snap_q;
    assign events     = events_q;
    assign missed     = missed_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_err_capture.sv
// Scoreboard bench for err_capture: two instances (EW=8 and EW=2) share stimulus; every irq
// rising edge pops an expected {snap_count, events} pair queued by the stimulus.
module tb_err_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        err;
    logic [11:0] count;
    logic        ack;

    logic        irq_a, irq_b;
    logic [11:0] snap_a, snap_b;
    logic [7:0]  events_a;
    logic [1:0]  events_b;
    logic        missed_a, missed_b;
    logic        busy_a, busy_b;

    int n_cmp = 0;
    int n_bad = 0;
    int ev    = 0;

    logic [31:0] qa_snap[$], qa_ev[$];
    logic [31:0] qb_snap[$], qb_ev[$];

    always #5 clk = ~clk;

    err_capture #(.CW(12), .QUAL(2), .EW(8)) dut_a (
        .clk(clk), .rst(rst), .err(err), .count(count), .ack(ack),
        .irq(irq_a), .snap_count(snap_a), .events(events_a),
        .missed(missed_a), .busy(busy_a)
    );

    err_capture #(.CW(12), .QUAL(2), .EW(2)) dut_b (
        .clk(clk), .rst(rst), .err(err), .count(count), .ack(ack),
        .irq(irq_b), .snap_count(snap_b), .events(events_b),
        .missed(missed_b), .busy(busy_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the commit that the next qualification must produce.
    task automatic expect_commit(input logic [11:0] snap);
        ev++;
        qa_snap.push_back({20'd0, snap});
        qa_ev.push_back(ev);
        qb_snap.push_back({20'd0, snap});
        qb_ev.push_back((ev > 3) ? 3 : ev);
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_irq"},    {31'd0, irq_a},    0);
        chk({name, "_snap"},   {20'd0, snap_a},   0);
        chk({name, "_events"}, {24'd0, events_a}, 0);
        chk({name, "_missed"}, {31'd0, missed_a}, 0);
        chk({name, "_busy"},   {31'd0, busy_a},   0);
        chk({name, "_irq_b"},  {31'd0, irq_b},    0);
    endtask

    // Monitors: irq rising edge is the DUT's "output valid".
    logic irq_a_prev = 1'b0, irq_b_prev = 1'b0;
    always @(negedge clk) begin
        if (irq_a && !irq_a_prev) begin
            if (qa_snap.size() == 0) begin
                chk("a_unexpected_irq", 1, 0);
            end else begin
                chk("a_snap", {20'd0, snap_a}, qa_snap.pop_front());
                chk("a_events", {24'd0, events_a}, qa_ev.pop_front());
            end
        end
        irq_a_prev = irq_a;
    end

    always @(negedge clk) begin
        if (irq_b && !irq_b_prev) begin
            if (qb_snap.size() == 0) begin
                chk("b_unexpected_irq", 1, 0);
            end else begin
                chk("b_snap", {20'd0, snap_b}, qb_snap.pop_front());
                chk("b_events", {30'd0, events_b}, qb_ev.pop_front());
            end
        end
        irq_b_prev = irq_b;
    end

    logic [11:0] sat_vals [0:1];

    initial begin
        rst = 1'b1; err = 1'b1; count = 12'h123; ack = 1'b0;
        #1;
        chk_idle_outputs("rst0");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle_outputs("rst_hold");
        end
        rst = 1'b0;

        // err still high after reset: commit of 0x123 at the 2nd edge
        expect_commit(12'h123);
        tick();
        chk("post_rst_e1_irq", {31'd0, irq_a}, 0);
        chk("post_rst_e1_busy", {31'd0, busy_a}, 1);
        tick();
        chk("post_rst_e2_irq", {31'd0, irq_a}, 1);
        chk("post_rst_snap", {20'd0, snap_a}, 32'h123);
        err = 1'b0; ack = 1'b1;
        tick();
        chk("ack_irq_drop", {31'd0, irq_a}, 0);
        chk("ack_to_idle", {31'd0, busy_a}, 0);
        ack = 1'b0;

        // glitch: one cycle high
        err = 1'b1;
        tick();
        chk("glitch_busy_hi", {31'd0, busy_a}, 1);
        err = 1'b0;
        tick();
        chk("glitch_busy_lo", {31'd0, busy_a}, 0);
        chk("glitch_irq", {31'd0, irq_a}, 0);
        chk("glitch_events", {24'd0, events_a}, 1);
        tick();

        // full event with count crossing wrap; err high through ack
        expect_commit(12'hffe);
        err = 1'b1; count = 12'hffe; tick();
        count = 12'hfff; tick();
        chk("full_irq", {31'd0, irq_a}, 1);
        chk("full_events", {24'd0, events_a}, 2);
        count = 12'h000; tick();
        ack = 1'b1; count = 12'h001; tick();
        chk("wl_irq", {31'd0, irq_a}, 0);
        chk("wl_busy", {31'd0, busy_a}, 1);
        ack = 1'b0; count = 12'h002; tick();
        chk("wl_hold_busy", {31'd0, busy_a}, 1);
        chk("wl_hold_irq", {31'd0, irq_a}, 0);
        err = 1'b0; tick();
        chk("wl_exit", {31'd0, busy_a}, 0);

        // rising edge coincident with ack: ack wins, missed stays 0
        expect_commit(12'h0a5);
        err = 1'b1; count = 12'h0a5; tick();
        count = 12'h0a6; tick();
        err = 1'b0; tick();
        err = 1'b1; ack = 1'b1; tick();
        chk("coinc_missed", {31'd0, missed_a}, 0);
        chk("coinc_irq", {31'd0, irq_a}, 0);
        chk("coinc_busy", {31'd0, busy_a}, 1);
        ack = 1'b0; err = 1'b0; tick();

        // rising edge in PEND without ack sets missed
        expect_commit(12'h03c);
        err = 1'b1; count = 12'h03c; tick();
        count = 12'h03d; tick();
        err = 1'b0; tick();
        chk("pre_missed", {31'd0, missed_a}, 0);
        err = 1'b1; tick();
        chk("missed_set", {31'd0, missed_a}, 1);
        chk("missed_events", {24'd0, events_a}, 4);
        chk("missed_irq", {31'd0, irq_a}, 1);
        err = 1'b0; ack = 1'b1; tick();
        ack = 1'b0;
        chk("missed_sticky", {31'd0, missed_a}, 1);

        // saturation of the EW=2 instance
        sat_vals[0] = 12'h111;
        sat_vals[1] = 12'h222;
        for (int k = 0; k < 2; k++) begin
            expect_commit(sat_vals[k]);
            err = 1'b1; count = sat_vals[k]; tick();
            count = 12'h000; tick();
            chk("sat_irq_b", {31'd0, irq_b}, 1);
            chk("sat_events_b", {30'd0, events_b}, 3);
            err = 1'b0; ack = 1'b1; tick();
            ack = 1'b0;
        end

        // reset while pending, with missed set
        expect_commit(12'h777);
        err = 1'b1; count = 12'h777; tick();
        tick();
        err = 1'b0; tick();
        err = 1'b1; tick();
        chk("pend_before_rst", {31'd0, irq_a}, 1);
        #2 rst = 1'b1;
        #1;
        chk_idle_outputs("mid_rst");
        tick();
        err = 1'b0; rst = 1'b0;
        tick();
        chk_idle_outputs("after_rst");

        chk("qa_drained", qa_snap.size(), 0);
        chk("qb_drained", qb_snap.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
